// File: rtl/pixel_buffer_rmw.sv
// Single-port SRAM arbiter for a pen-drawn frame buffer: display word fetch,
// pen read-modify-write (set one pixel) and full-frame erase, in that priority.
module pixel_buffer_rmw #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase_button,
    input  logic              pen_valid,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [10:0]       hcounter,
    input  logic [9:0]        vcounter,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_read,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] pixel_buf,
    output logic              pixel_buf_valid,
    output logic              erase_busy,
    output logic              erase_done,
    output logic              fetch_overrun,
    output logic [3:0]        ram_state
);

    localparam int unsigned WORDS     = H_VISIBLE / DATA_W;
    localparam int unsigned FB_WORDS  = WORDS * V_VISIBLE;
    localparam int unsigned BIT_W     = $clog2(DATA_W);
    localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0] H_MASK    = 11'(DATA_W - 1);
    localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0]  V_ERASE   = 10'(V_VISIBLE + 1);
    localparam logic [ADDR_W-1:0] WORDS_A   = ADDR_W'(WORDS);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StFReq  = 4'd1,
        StFWait = 4'd2,
        StFCap  = 4'd3,
        StPReq  = 4'd4,
        StPWait = 4'd5,
        StPCap  = 4'd6,
        StPWr   = 4'd7,
        StEReq  = 4'd8,
        StEWait = 4'd9
    } state_e;

    state_e              state_q, state_d;
    logic                fetch_pending_q, pen_pending_q, erase_busy_q;
    logic                erase_done_q, fetch_overrun_q;
    logic [ADDR_W-1:0]   fetch_addr_q, addr_q, erase_ptr_q;
    logic [9:0]          pen_x_q, pen_y_q;
    logic [BIT_W-1:0]    pen_bit_q;
    logic [DATA_W-1:0]   wr_data_q, pixel_buf_q;

    logic                fetch_trig, pen_trig, pen_in_range, erase_trig;
    logic                fetch_take, pen_take, erase_step;
    logic [ADDR_W-1:0]   fetch_addr_calc, pen_addr_calc;
    logic [DATA_W-1:0]   pen_mask;

    assign fetch_trig   = ((hcounter & H_MASK) == '0) && (hcounter < H_VIS) &&
                          (vcounter < V_VIS);
    assign pen_trig     = (hcounter == '0) && (vcounter == V_VIS) && pen_valid;
    assign pen_in_range = ({1'b0, x} < H_VIS) && (y < V_VIS);
    assign erase_trig   = (hcounter == '0) && (vcounter == V_ERASE) && erase_button;

    assign fetch_addr_calc = ADDR_W'(vcounter) * WORDS_A + ADDR_W'(hcounter >> BIT_W);
    assign pen_addr_calc   = ADDR_W'(pen_y_q) * WORDS_A + ADDR_W'(pen_x_q >> BIT_W);
    assign pen_mask        = DATA_W'(1) << pen_bit_q;

    always_comb begin
        state_d         = state_q;
        address         = '0;
        data_write      = '0;
        read            = 1'b0;
        write           = 1'b0;
        pixel_buf_valid = 1'b0;
        fetch_take      = 1'b0;
        pen_take        = 1'b0;
        erase_step      = 1'b0;
        case (state_q)
            StIdle: begin
                if (fetch_pending_q)    state_d = StFReq;
                else if (pen_pending_q) state_d = StPReq;
                else if (erase_busy_q)  state_d = StEReq;
            end
            StFReq: begin
                address = fetch_addr_q;
                if (ready) begin
                    fetch_take = 1'b1;
                    state_d    = StFWait;
                end
            end
            StFWait: begin
                address = addr_q;
                read    = 1'b1;
                state_d = StFCap;
            end
            StFCap: begin
                pixel_buf_valid = 1'b1;
                state_d         = StIdle;
            end
            StPReq: begin
                address = pen_addr_calc;
                if (ready) begin
                    pen_take = 1'b1;
                    state_d  = StPWait;
                end
            end
            StPWait: begin
                address = addr_q;
                read    = 1'b1;
                state_d = StPCap;
            end
            StPCap: begin
                address    = addr_q;
                data_write = data_read | pen_mask;
                state_d    = StPWr;
            end
            StPWr: begin
                address    = addr_q;
                data_write = wr_data_q;
                if (ready) begin
                    write   = 1'b1;
                    state_d = StIdle;
                end
            end
            StEReq: begin
                address = erase_ptr_q;
                if (ready) state_d = StEWait;
            end
            StEWait: begin
                // Return to idle after every word so fetch/pen can cut in.
                address    = erase_ptr_q;
                write      = 1'b1;
                erase_step = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= StIdle;
            fetch_pending_q <= 1'b0;
            pen_pending_q   <= 1'b0;
            erase_busy_q    <= 1'b0;
            erase_done_q    <= 1'b0;
            fetch_overrun_q <= 1'b0;
            fetch_addr_q    <= '0;
            addr_q          <= '0;
            erase_ptr_q     <= '0;
            pen_x_q         <= '0;
            pen_y_q         <= '0;
            pen_bit_q       <= '0;
            wr_data_q       <= '0;
            pixel_buf_q     <= '0;
        end else begin
            state_q      <= state_d;
            erase_done_q <= 1'b0;

            // A new trigger wins over the clear of the request being serviced.
            if (fetch_trig) begin
                fetch_pending_q <= 1'b1;
                fetch_addr_q    <= fetch_addr_calc;
                if (fetch_pending_q) fetch_overrun_q <= 1'b1;
            end else if (fetch_take) begin
                fetch_pending_q <= 1'b0;
            end

            if (pen_trig && pen_in_range) begin
                pen_pending_q <= 1'b1;
                pen_x_q       <= x;
                pen_y_q       <= y;
            end else if (pen_take) begin
                pen_pending_q <= 1'b0;
            end

            if (fetch_take) begin
                addr_q <= fetch_addr_q;
            end else if (pen_take) begin
                addr_q    <= pen_addr_calc;
                pen_bit_q <= pen_x_q[BIT_W-1:0];
            end

            if (state_q == StPCap) wr_data_q <= data_write;
            if (state_q == StFCap) pixel_buf_q <= data_read;

            if (erase_trig) begin
                erase_busy_q <= 1'b1;
                erase_ptr_q  <= '0;
            end else if (erase_step) begin
                erase_ptr_q <= erase_ptr_q + 1'b1;
                if (erase_ptr_q == LAST_WORD) begin
                    erase_busy_q <= 1'b0;
                    erase_done_q <= 1'b1;
                end
            end
        end
    end

    assign pixel_buf     = (state_q == StFCap) ? data_read : pixel_buf_q;
    assign erase_busy    = erase_busy_q;
    assign erase_done    = erase_done_q;
    assign fetch_overrun = fetch_overrun_q;
    assign ram_state     = state_q;

endmodule
